// File: rtl/uart_rx_oversample.sv
// Oversampling 8N1 UART receiver: 2-flop synchronizer, free-running sample tick,
// 3-sample majority vote at mid-bit, false-start rejection and stop-bit checking.
module uart_rx_oversample #(
   parameter int unsigned CLK_FREQ   = 100_000_000,
   parameter int unsigned BAUD       = 115_200,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_ready,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned PH_W   = $clog2(OVERSAMPLE);
   localparam int unsigned M      = OVERSAMPLE / 2;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OVERSAMPLE - 1);
   localparam logic [PH_W-1:0]  PH_S0    = PH_W'(M - 1);
   localparam logic [PH_W-1:0]  PH_S1    = PH_W'(M);
   localparam logic [PH_W-1:0]  PH_VOTE  = PH_W'(M + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   logic             rx_meta;
   logic             rx_s;
   logic [DIV_W-1:0] div_cnt;
   logic             tick_c;
   logic             vote_c;

   state_t           state_q,  state_d;
   logic [PH_W-1:0]  phase_q,  phase_d;
   logic [2:0]       bitcnt_q, bitcnt_d;
   logic [7:0]       shift_q,  shift_d;
   logic [1:0]       samp_q,   samp_d;
   logic [7:0]       data_d;
   logic             ready_d;
   logic             ferr_d;
   logic             busy_d;

   // Two-flop synchronizer; idle-high line so both flops reset to 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // Free-running sample tick; never resynchronized to the line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   assign tick_c = (div_cnt == DIV_LAST);

   // Third sample is the live synchronized line at the vote tick.
   assign vote_c = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         phase_q   <= '0;
         bitcnt_q  <= '0;
         shift_q   <= '0;
         samp_q    <= '0;
         rx_data   <= '0;
         rx_ready  <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         bitcnt_q  <= bitcnt_d;
         shift_q   <= shift_d;
         samp_q    <= samp_d;
         rx_data   <= data_d;
         rx_ready  <= ready_d;
         frame_err <= ferr_d;
         busy      <= busy_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      samp_d   = samp_q;
      data_d   = rx_data;
      ready_d  = 1'b0;
      ferr_d   = 1'b0;

      if (tick_c) begin
         if (phase_q == PH_S0) samp_d[0] = rx_s;
         if (phase_q == PH_S1) samp_d[1] = rx_s;

         case (state_q)
            S_IDLE: begin
               if (!rx_s) begin
                  state_d = S_START;
                  phase_d = '0;
               end
            end
            S_START: begin
               phase_d = phase_q + PH_W'(1);
               if (phase_q == PH_VOTE && vote_c) begin
                  state_d = S_IDLE;
                  phase_d = '0;
               end else if (phase_q == PH_LAST) begin
                  state_d  = S_DATA;
                  phase_d  = '0;
                  bitcnt_d = '0;
               end
            end
            S_DATA: begin
               phase_d = phase_q + PH_W'(1);
               if (phase_q == PH_VOTE) shift_d = {vote_c, shift_q[7:1]};
               if (phase_q == PH_LAST) begin
                  phase_d = '0;
                  if (bitcnt_q == 3'd7) state_d = S_STOP;
                  else                  bitcnt_d = bitcnt_q + 3'd1;
               end
            end
            S_STOP: begin
               phase_d = phase_q + PH_W'(1);
               if (phase_q == PH_VOTE) begin
                  phase_d = '0;
                  if (vote_c) begin
                     data_d  = shift_q;
                     ready_d = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = S_BREAK;
                  end
               end
            end
            S_BREAK: begin
               if (rx_s) state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
               phase_d = '0;
            end
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

endmodule
